if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage of a classic 5-stage pipeline.
//               Holds the program counter, selects the next PC, captures
//               the fetched instruction into the IF/ID pipeline register
//               and keeps stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             IF_ID_Write,
   input  logic             IF_Flush,
   input  logic [1:0]       pc_src,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      jump_target,
   input  logic [31:0]      instr_in,
   output logic [31:0]      pc_out,
   output logic [31:0]      IF_ID_PC4,
   output logic [31:0]      IF_ID_Instr,
   output logic             IF_ID_Valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Next-PC source encodings; 11 is reserved and behaves as sequential.
   localparam logic [1:0] c_SRC_SEQ    = 2'b00;
   localparam logic [1:0] c_SRC_BRANCH = 2'b01;
   localparam logic [1:0] c_SRC_JUMP   = 2'b10;

   // Counters stop here instead of wrapping back to zero.
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Architectural state
   logic [31:0]      pc_q,          pc_d;
   logic [31:0]      ifid_pc4_q,    ifid_pc4_d;
   logic [31:0]      ifid_instr_q,  ifid_instr_d;
   logic             ifid_valid_q,  ifid_valid_d;
   logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

   // Combinational helpers
   logic [31:0]      pc_plus4;
   logic [31:0]      next_pc;

   // Sequential successor; the 32-bit add wraps naturally past 32'hFFFF_FFFC.
   // PC low bits are never masked, so misaligned targets pass through as-is.
   assign pc_plus4 = pc_q + 32'd4;

   // Next-PC multiplexer driven by the control decision made in ID.
   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         c_SRC_SEQ    : next_pc = pc_plus4;
         c_SRC_BRANCH : next_pc = branch_target;
         c_SRC_JUMP   : next_pc = jump_target;
         default      : next_pc = pc_plus4;
      endcase
   end

   // PC update: a hazard stall (PCWrite=0) freezes the PC whatever pc_src says.
   always_comb begin
      pc_d = pc_q;
      if (PCWrite) begin
         pc_d = next_pc;
      end
   end

   // IF/ID update: a flush beats a write-enable so a squashed fetch never
   // reaches ID; with neither, the register holds (stall or dropped fetch).
   always_comb begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      if (IF_Flush) begin
         ifid_pc4_d   = pc_plus4;
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
      end else if (IF_ID_Write) begin
         ifid_pc4_d   = pc_plus4;
         ifid_instr_d = instr_in;
         ifid_valid_d = 1'b1;
      end
   end

   // Saturating event counters; both may step on the same edge.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!PCWrite && (stall_cnt_q != c_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + c_CNT_ONE;
      end
      if (IF_Flush && (flush_cnt_q != c_CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + c_CNT_ONE;
      end
   end

   // State registers; reset acts immediately and masks every other input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ifid_pc4_q   <= 32'h0000_0000;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   // Outputs come straight from registers: no input-to-output path exists.
   assign pc_out      = pc_q;
   assign IF_ID_PC4   = ifid_pc4_q;
   assign IF_ID_Instr = ifid_instr_q;
   assign IF_ID_Valid = ifid_valid_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage (CNT_W = 4 so that
//               counter saturation is reachable in a few cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_stage;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             PCWrite;
   logic             IF_ID_Write;
   logic             IF_Flush;
   logic [1:0]       pc_src;
   logic [31:0]      branch_target;
   logic [31:0]      jump_target;
   logic [31:0]      instr_in;
   logic [31:0]      pc_out;
   logic [31:0]      IF_ID_PC4;
   logic [31:0]      IF_ID_Instr;
   logic             IF_ID_Valid;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000),
      .CNT_W     (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .IF_Flush      (IF_Flush),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .instr_in      (instr_in),
      .pc_out        (pc_out),
      .IF_ID_PC4     (IF_ID_PC4),
      .IF_ID_Instr   (IF_ID_Instr),
      .IF_ID_Valid   (IF_ID_Valid),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 ns before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pcw, input logic ifw, input logic fl,
                        input logic [1:0] src, input logic [31:0] instr);
      PCWrite     = pcw;
      IF_ID_Write = ifw;
      IF_Flush    = fl;
      pc_src      = src;
      instr_in    = instr;
   endtask

   // Reset applied before any clock edge must take effect immediately,
   // and must hold through edges while other inputs are active.
   task automatic test_reset();
      rst = 1'b1;
      branch_target = 32'h0000_0100;
      jump_target   = 32'h0000_0200;
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'hAAAA_AAAA);
      #1;
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc actual=%h required=%h", pc_out, 32'h0); end
      total++; if (IF_ID_Instr !== 32'h0) begin bad++; $display("FAIL rst_instr actual=%h required=%h", IF_ID_Instr, 32'h0); end
      total++; if (IF_ID_PC4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 actual=%h required=%h", IF_ID_PC4, 32'h0); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_stall actual=%0d required=%0d", stall_cnt, 0); end
      total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL rst_flush actual=%0d required=%0d", flush_cnt, 0); end
      // Edges with rst high and stall/flush requested must change nothing.
      drive(1'b0, 1'b1, 1'b1, 2'b01, 32'hAAAA_AAAA);
      step();
      step();
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_hold_pc actual=%h required=%h", pc_out, 32'h0); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_hold_stall actual=%0d required=%0d", stall_cnt, 0); end
      total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL rst_hold_flush actual=%0d required=%0d", flush_cnt, 0); end
      // Release between edges.
      #2;
      rst = 1'b0;
   endtask

   // Two back-to-back sequential fetches from address 0.
   task automatic test_seq_fetch();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h8C08_0004);
      step();
      total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL seq_pc actual=%h required=%h", pc_out, 32'h4); end
      total++; if (IF_ID_Instr !== 32'h8C08_0004) begin bad++; $display("FAIL seq_instr actual=%h required=%h", IF_ID_Instr, 32'h8C08_0004); end
      total++; if (IF_ID_PC4 !== 32'h4) begin bad++; $display("FAIL seq_pc4 actual=%h required=%h", IF_ID_PC4, 32'h4); end
      total++; if (IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL seq_valid actual=%b required=%b", IF_ID_Valid, 1'b1); end
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h1111_1111);
      step();
      total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL seq2_pc actual=%h required=%h", pc_out, 32'h8); end
      total++; if (IF_ID_Instr !== 32'h1111_1111) begin bad++; $display("FAIL seq2_instr actual=%h required=%h", IF_ID_Instr, 32'h1111_1111); end
      total++; if (IF_ID_PC4 !== 32'h8) begin bad++; $display("FAIL seq2_pc4 actual=%h required=%h", IF_ID_PC4, 32'h8); end
   endtask

   // Load-use stall at PC 8 with a branch select that must be ignored.
   task automatic test_stall();
      branch_target = 32'h0000_0100;
      drive(1'b0, 1'b0, 1'b0, 2'b01, 32'hDEAD_BEEF);
      step();
      total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL stall_pc actual=%h required=%h", pc_out, 32'h8); end
      total++; if (IF_ID_Instr !== 32'h1111_1111) begin bad++; $display("FAIL stall_instr actual=%h required=%h", IF_ID_Instr, 32'h1111_1111); end
      total++; if (IF_ID_PC4 !== 32'h8) begin bad++; $display("FAIL stall_pc4 actual=%h required=%h", IF_ID_PC4, 32'h8); end
      total++; if (IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL stall_valid actual=%b required=%b", IF_ID_Valid, 1'b1); end
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL stall_cnt actual=%0d required=%0d", stall_cnt, 1); end
      total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL stall_flushcnt actual=%0d required=%0d", flush_cnt, 0); end
      // Resume: fetch at 8 then at 12, reaching PC 16.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h2222_2222);
      step();
      total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL resume_pc actual=%h required=%h", pc_out, 32'hC); end
      total++; if (IF_ID_Instr !== 32'h2222_2222) begin bad++; $display("FAIL resume_instr actual=%h required=%h", IF_ID_Instr, 32'h2222_2222); end
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL resume_stallcnt actual=%0d required=%0d", stall_cnt, 1); end
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h3333_3333);
      step();
      total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL resume2_pc actual=%h required=%h", pc_out, 32'h10); end
      total++; if (IF_ID_PC4 !== 32'h10) begin bad++; $display("FAIL resume2_pc4 actual=%h required=%h", IF_ID_PC4, 32'h10); end
   endtask

   // Taken branch from PC 16 to 0x40 squashes the fetched instruction.
   task automatic test_branch_flush();
      branch_target = 32'h0000_0040;
      drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h4444_4444);
      step();
      total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL br_pc actual=%h required=%h", pc_out, 32'h40); end
      total++; if (IF_ID_Instr !== 32'h0) begin bad++; $display("FAIL br_instr actual=%h required=%h", IF_ID_Instr, 32'h0); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL br_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      total++; if (IF_ID_PC4 !== 32'h14) begin bad++; $display("FAIL br_pc4 actual=%h required=%h", IF_ID_PC4, 32'h14); end
      total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL br_flushcnt actual=%0d required=%0d", flush_cnt, 1); end
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL br_stallcnt actual=%0d required=%0d", stall_cnt, 1); end
   endtask

   // Flush beats IF_ID_Write=0; PCWrite=0 beats a jump; both counters step.
   task automatic test_priority();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h5555_5555);
      step();
      total++; if (IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL prio_pre_valid actual=%b required=%b", IF_ID_Valid, 1'b1); end
      jump_target = 32'h0000_0080;
      drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h6666_6666);
      step();
      total++; if (pc_out !== 32'h44) begin bad++; $display("FAIL prio_pc actual=%h required=%h", pc_out, 32'h44); end
      total++; if (IF_ID_Instr !== 32'h0) begin bad++; $display("FAIL prio_instr actual=%h required=%h", IF_ID_Instr, 32'h0); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL prio_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      total++; if (IF_ID_PC4 !== 32'h48) begin bad++; $display("FAIL prio_pc4 actual=%h required=%h", IF_ID_PC4, 32'h48); end
      total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL prio_stallcnt actual=%0d required=%0d", stall_cnt, 2); end
      total++; if (flush_cnt !== 4'd2) begin bad++; $display("FAIL prio_flushcnt actual=%0d required=%0d", flush_cnt, 2); end
   endtask

   // PC advances (jump to top of memory) while IF/ID holds, then wraps.
   task automatic test_drop_and_wrap();
      jump_target = 32'hFFFF_FFFC;
      drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h6666_6666);
      step();
      total++; if (pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL drop_pc actual=%h required=%h", pc_out, 32'hFFFF_FFFC); end
      total++; if (IF_ID_Instr !== 32'h0) begin bad++; $display("FAIL drop_instr actual=%h required=%h", IF_ID_Instr, 32'h0); end
      total++; if (IF_ID_PC4 !== 32'h48) begin bad++; $display("FAIL drop_pc4 actual=%h required=%h", IF_ID_PC4, 32'h48); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL drop_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      drive(1'b1, 1'b1, 1'b0, 2'b11, 32'h7777_7777);
      step();
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap_pc actual=%h required=%h", pc_out, 32'h0); end
      total++; if (IF_ID_PC4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 actual=%h required=%h", IF_ID_PC4, 32'h0); end
      total++; if (IF_ID_Instr !== 32'h7777_7777) begin bad++; $display("FAIL wrap_instr actual=%h required=%h", IF_ID_Instr, 32'h7777_7777); end
      total++; if (IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL wrap_valid actual=%b required=%b", IF_ID_Valid, 1'b1); end
   endtask

   // 20 stall cycles from 2 must stop at 15; then 20 flushes from 2 likewise.
   task automatic test_saturation();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h8888_8888);
      for (int i = 0; i < 12; i++) step();
      total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_stall_14 actual=%0d required=%0d", stall_cnt, 14); end
      for (int i = 0; i < 8; i++) step();
      total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall_15 actual=%0d required=%0d", stall_cnt, 15); end
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL sat_pc actual=%h required=%h", pc_out, 32'h0); end
      drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h8888_8888);
      for (int i = 0; i < 20; i++) step();
      total++; if (flush_cnt !== 4'd15) begin bad++; $display("FAIL sat_flush actual=%0d required=%0d", flush_cnt, 15); end
      total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall_keep actual=%0d required=%0d", stall_cnt, 15); end
      total++; if (pc_out !== 32'h50) begin bad++; $display("FAIL sat_flush_pc actual=%h required=%h", pc_out, 32'h50); end
   endtask

   // Reset between edges with stall_cnt=5, then normal fetch from RESET_PC.
   task automatic test_async_reset();
      #2; rst = 1'b1; #2; rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h9999_9999);
      for (int i = 0; i < 5; i++) step();
      total++; if (stall_cnt !== 4'd5) begin bad++; $display("FAIL ar_pre_stall actual=%0d required=%0d", stall_cnt, 5); end
      drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h9999_9999);
      step();
      total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL ar_pre_pc actual=%h required=%h", pc_out, 32'h40); end
      // Assert reset mid-cycle and sample before the next edge.
      #2; rst = 1'b1; #1;
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL ar_pc actual=%h required=%h", pc_out, 32'h0); end
      total++; if (IF_ID_Instr !== 32'h0) begin bad++; $display("FAIL ar_instr actual=%h required=%h", IF_ID_Instr, 32'h0); end
      total++; if (IF_ID_PC4 !== 32'h0) begin bad++; $display("FAIL ar_pc4 actual=%h required=%h", IF_ID_PC4, 32'h0); end
      total++; if (IF_ID_Valid !== 1'b0) begin bad++; $display("FAIL ar_valid actual=%b required=%b", IF_ID_Valid, 1'b0); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL ar_stall actual=%0d required=%0d", stall_cnt, 0); end
      total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL ar_flush actual=%0d required=%0d", flush_cnt, 0); end
      step();
      #2; rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'hABCD_0123);
      step();
      total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL ar_fetch_pc actual=%h required=%h", pc_out, 32'h4); end
      total++; if (IF_ID_Instr !== 32'hABCD_0123) begin bad++; $display("FAIL ar_fetch_instr actual=%h required=%h", IF_ID_Instr, 32'hABCD_0123); end
      total++; if (IF_ID_PC4 !== 32'h4) begin bad++; $display("FAIL ar_fetch_pc4 actual=%h required=%h", IF_ID_PC4, 32'h4); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL ar_fetch_stall actual=%0d required=%0d", stall_cnt, 0); end
      total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL ar_fetch_flush actual=%0d required=%0d", flush_cnt, 0); end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_branch_flush();
      test_priority();
      test_drop_and_wrap();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
